cmplx_twiddle_mult: RTL
=======================

# cmplx_twiddle_mult

Pipelined, parametrised signed fixed-point complex multiplier for the FFT butterfly datapath. It computes din × W on complex operands (twiddle multiply) with selectable round-half-up or truncation and optional saturation. It carries a valid/ready handshake with backpressure and a sticky overflow flag. It sits between the twiddle ROM / input reorder stage and the butterfly add/subtract stage, and is the successor to the single-lane combinational real multiplier.

## Interface
- DIN_W, 16, data operand width (two's complement)
- W_W, 16, twiddle operand width (two's complement)
- FRAC, 14, fractional bits of the twiddle. Result = full product arithmetic-shifted right by FRAC.
- DOUT_W, 16, output width per lane
- ROUND, 1, 1 = round half up (add 2^(FRAC-1) before shift); 0 = truncate (floor)
- SAT, 1, 1 = saturate to DOUT_W range; 0 = wrap (keep low DOUT_W bits after shift)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block accepts input this cycle
- din_re, din_im  in  DIN_W each  data operand
- w_re, w_im  in  W_W each  twiddle operand
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- dout_re, dout_im  out  DOUT_W each  result
- ovf  out  1  sticky: a saturation occurred since last clear
- ovf_clr  in  1  clears ovf

## Operation
- Real lane: re = din_re·w_re − din_im·w_im. Imaginary lane: im = din_re·w_im + din_im·w_re.
- Widths:
  - Products are DIN_W+W_W bits, signed, full precision (no sign-magnitude conversion; −2^(DIN_W−1) operands are handled exactly).
  - Sums are DIN_W+W_W+1 bits.
  - The rounding add is performed at DIN_W+W_W+2 bits so it never overflows.
- Scaling: after rounding, arithmetic shift right by FRAC.
- Saturation:
  - SAT=1: clamp to [−2^(DOUT_W−1), 2^(DOUT_W−1)−1].
  - Each lane that clamps raises a per-transfer overflow event.
- Sticky flag:
  - ovf sets when a saturating result enters the output register.
  - ovf clears on ovf_clr.
  - Set and clear in the same cycle: set wins.
  - ovf never sets when SAT=0.
- Handshake: a transfer occurs on in_valid & in_ready and on out_valid & out_ready. Inputs are sampled only on an input transfer.

## Timing
- Pipeline has 4 register stages:
  - S1: operand capture.
  - S2: four products.
  - S3: add/sub.
  - S4: round/shift/saturate, which is the output register.
- Latency is 4 cycles from input transfer to out_valid with no stall.
- Throughput is 1 per cycle.
- Global enable: en = ~out_valid | out_ready.
  - All stages and their valid bits advance only when en=1.
  - in_ready = en. This is combinational from out_ready and out_valid; this path is documented.
- Bubbles are not collapsed: a stalled pipeline holds all stages, including empty ones.
- out_valid holds and dout_* are stable while out_valid & ~out_ready.
- Reset (rst_n=0 at a clock edge):
  - All stage valids = 0, out_valid = 0, dout_re = dout_im = 0, ovf = 0.
  - Any in-flight data is discarded.
  - A reset asserted mid-stall takes priority over hold.
  - in_ready is 1 in the first cycle after reset.
- Simultaneous input and output transfer in the same cycle is legal and sustains full rate.

## Structure
- Shared package fft_pkg holds:
  - Default widths (DATA_W=16, TW_W=16, TW_FRAC=14).
  - Localparams ROUND_HALF_UP=1 and ROUND_TRUNC=0.
  - The Q1.14 constants ONE=16384 and MINUS_ONE=−16384.
- One sub-module, fxp_round_sat: a single lane that takes the sum, applies ROUND, the FRAC shift and SAT, and outputs a DOUT_W result plus a sat flag. It is combinational, and the parent registers its output as S4. It is instantiated twice, once per lane.
- Top level: S1–S3 registers, the valid chain, the enable logic and the ovf register.

## Test plan
All scenarios use defaults unless a parameter is stated.
- Identity: din=(16384,0), w=(16384,0). After 4 cycles, dout=(16384,0), ovf=0.
- −j rotation: din=(1000,2000), w=(0,−16384) → dout=(2000,−1000).
- Rounding:
  - ROUND=1: din=(1,0), w=(8192,0) → dout_re=1; din=(−1,0), w=(8192,0) → dout_re=0.
  - ROUND=0: the same two inputs give 0 and −1.
- Saturation:
  - din=(−32768,−32768), w=(−32768,0) → dout=(32767,32767), ovf=1 one cycle later and held.
  - ovf_clr pulsed while another saturating result arrives → ovf stays 1.
  - ovf_clr pulsed alone → ovf=0.
- Backpressure:
  - Stream 8 inputs back-to-back with out_ready low for 3 cycles mid-stream (in_ready must drop while the output is full).
  - All 8 results emerge in order, none dropped or duplicated, and dout stays stable while stalled.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 3 items in flight. out_valid=0 and dout=0 next cycle, no stale item emerges afterwards, and the next input appears 4 cycles after acceptance.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath package: default widths, rounding-mode selectors and
// the Q1.14 twiddle constants used across the butterfly pipeline.
package fft_pkg;

   localparam int DATA_W  = 16;
   localparam int TW_W    = 16;
   localparam int TW_FRAC = 14;

   localparam int ROUND_HALF_UP = 1;
   localparam int ROUND_TRUNC   = 0;

   localparam logic signed [15:0] ONE       = 16'sd16384;
   localparam logic signed [15:0] MINUS_ONE = -16'sd16384;

endpackage

// File: rtl/cmplx_twiddle_mult_if.sv
// Handshake/data bundle of the complex twiddle multiplier. The slave modport
// is the multiplier's view, the master modport is the surrounding datapath's.
interface cmplx_twiddle_mult_if
   import fft_pkg::*;
#(
   parameter int DIN_W  = DATA_W,
   parameter int W_W    = TW_W,
   parameter int DOUT_W = DATA_W
);

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DIN_W-1:0]  din_re;
   logic signed [DIN_W-1:0]  din_im;
   logic signed [W_W-1:0]    w_re;
   logic signed [W_W-1:0]    w_im;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DOUT_W-1:0] dout_re;
   logic signed [DOUT_W-1:0] dout_im;
   logic                     ovf;
   logic                     ovf_clr;

   modport slave (
      input  in_valid, din_re, din_im, w_re, w_im, out_ready, ovf_clr,
      output in_ready, out_valid, dout_re, dout_im, ovf
   );

   modport master (
      output in_valid, din_re, din_im, w_re, w_im, out_ready, ovf_clr,
      input  in_ready, out_valid, dout_re, dout_im, ovf
   );

endinterface

// File: rtl/fxp_round_sat.sv
// Single-lane fixed-point post-processor: optional round-half-up, arithmetic
// shift right by FRAC, then saturate or wrap to DOUT_W bits. Purely
// combinational; the parent registers the result.
module fxp_round_sat
   import fft_pkg::*;
#(
   parameter int IN_W   = 33,
   parameter int FRAC   = TW_FRAC,
   parameter int DOUT_W = DATA_W,
   parameter int ROUND  = ROUND_HALF_UP,
   parameter int SAT    = 1
) (
   input  logic signed [IN_W-1:0]   sum_i,
   output logic signed [DOUT_W-1:0] dout_o,
   output logic                     sat_o
);

   // One extra bit of headroom so the rounding add can never overflow.
   localparam int EXT_W = IN_W + 1;
   localparam int HALF_SH = (FRAC > 0) ? FRAC - 1 : 0;
   localparam logic signed [EXT_W-1:0] HALF =
      (ROUND != 0 && FRAC > 0) ? EXT_W'(64'sd1 <<< HALF_SH) : '0;
   localparam logic signed [EXT_W-1:0] MAXV = EXT_W'((64'sd1 <<< (DOUT_W-1)) - 64'sd1);
   localparam logic signed [EXT_W-1:0] MINV = EXT_W'(-(64'sd1 <<< (DOUT_W-1)));

   logic signed [EXT_W-1:0] ext;
   logic signed [EXT_W-1:0] rounded;
   logic signed [EXT_W-1:0] shifted;

   // Round, scale back to the data's binary point, then clamp or wrap.
   always_comb begin
      ext     = {sum_i[IN_W-1], sum_i};
      rounded = ext + HALF;
      shifted = rounded >>> FRAC;
      dout_o  = shifted[DOUT_W-1:0];
      sat_o   = 1'b0;
      if (SAT != 0) begin
         if (shifted > MAXV) begin
            dout_o = MAXV[DOUT_W-1:0];
            sat_o  = 1'b1;
         end else if (shifted < MINV) begin
            dout_o = MINV[DOUT_W-1:0];
            sat_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cmplx_twiddle_mult.sv
// Four-stage pipelined complex twiddle multiplier (din x W) for the FFT
// butterfly. A single global enable stalls every stage, bubbles included,
// whenever the output register holds a result nobody has taken.
module cmplx_twiddle_mult
   import fft_pkg::*;
#(
   parameter int DIN_W  = DATA_W,
   parameter int W_W    = TW_W,
   parameter int FRAC   = TW_FRAC,
   parameter int DOUT_W = DATA_W,
   parameter int ROUND  = ROUND_HALF_UP,
   parameter int SAT    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cmplx_twiddle_mult_if.slave  bus
);

   localparam int PROD_W = DIN_W + W_W;
   localparam int SUM_W  = PROD_W + 1;

   logic                     en;
   logic                     s1Valid_q, s2Valid_q, s3Valid_q, outValid_q;
   logic signed [DIN_W-1:0]  aRe_q, aIm_q;
   logic signed [W_W-1:0]    bRe_q, bIm_q;
   logic signed [PROD_W-1:0] pRR_q, pII_q, pRI_q, pIR_q;
   logic signed [SUM_W-1:0]  sumRe_q, sumIm_q;
   logic signed [DOUT_W-1:0] rsRe, rsIm, doutRe_q, doutIm_q;
   logic                     satRe, satIm;
   logic                     ovf_q, ovf_d;

   assign en           = ~outValid_q | bus.out_ready;
   assign bus.in_ready = en;
   assign bus.out_valid = outValid_q;
   assign bus.dout_re  = doutRe_q;
   assign bus.dout_im  = doutIm_q;
   assign bus.ovf      = ovf_q;

   // Valid chain; reset discards everything in flight, even during a stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1Valid_q <= 1'b0;
         s2Valid_q <= 1'b0;
         s3Valid_q <= 1'b0;
      end else if (en) begin
         s1Valid_q <= bus.in_valid;
         s2Valid_q <= s1Valid_q;
         s3Valid_q <= s2Valid_q;
      end
   end

   // Datapath S1-S3: operand capture, four full-precision products, add/sub.
   always_ff @(posedge clk) begin
      if (en) begin
         if (bus.in_valid) begin
            aRe_q <= bus.din_re;
            aIm_q <= bus.din_im;
            bRe_q <= bus.w_re;
            bIm_q <= bus.w_im;
         end
         pRR_q   <= PROD_W'(aRe_q) * PROD_W'(bRe_q);
         pII_q   <= PROD_W'(aIm_q) * PROD_W'(bIm_q);
         pRI_q   <= PROD_W'(aRe_q) * PROD_W'(bIm_q);
         pIR_q   <= PROD_W'(aIm_q) * PROD_W'(bRe_q);
         sumRe_q <= SUM_W'(pRR_q) - SUM_W'(pII_q);
         sumIm_q <= SUM_W'(pRI_q) + SUM_W'(pIR_q);
      end
   end

   fxp_round_sat #(
      .IN_W(SUM_W), .FRAC(FRAC), .DOUT_W(DOUT_W), .ROUND(ROUND), .SAT(SAT)
   ) uRoundRe (
      .sum_i(sumRe_q), .dout_o(rsRe), .sat_o(satRe)
   );

   fxp_round_sat #(
      .IN_W(SUM_W), .FRAC(FRAC), .DOUT_W(DOUT_W), .ROUND(ROUND), .SAT(SAT)
   ) uRoundIm (
      .sum_i(sumIm_q), .dout_o(rsIm), .sat_o(satIm)
   );

   // S4 output register; data only moves on a real result so dout stays put otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         doutRe_q   <= '0;
         doutIm_q   <= '0;
      end else if (en) begin
         outValid_q <= s3Valid_q;
         if (s3Valid_q) begin
            doutRe_q <= rsRe;
            doutIm_q <= rsIm;
         end
      end
   end

   // Sticky overflow next state: a clamping result entering S4 beats a clear.
   always_comb begin
      ovf_d = ovf_q;
      if (bus.ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (en && s3Valid_q && (satRe || satIm)) begin
         ovf_d = 1'b1;
      end
   end

   // Sticky overflow register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

endmodule
